// File: rtl/rgb_frame_reader.sv
// Purpose: reads frames from a two-bank SRAM and drives a parallel RGB panel with sync timing.
// Latency: pixel, DE and sync outputs follow the counter position by one pixel slot (2 Sys_Clock).
// Backpressure: none; the panel is free-running while Display_EN=1, and Display_EN=0 abandons the frame.
// Ports: Sys_Clock/Reset (async, active-low); Display_EN runs timing; Bank_Sel = bank last written upstream;
//        Data_Bus = SRAM read data; Addr/EN/WE = SRAM read port; Frame_Start = frame-origin pulse;
//        Read_Bank = bank on display; RGB_* = panel clock, active-low syncs, data enable and pixel data.
module rgb_frame_reader #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 48,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 13,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 32
) (
  input  logic        Sys_Clock,
  input  logic        Reset,
  input  logic        Display_EN,
  input  logic        Bank_Sel,
  input  logic [26:0] Data_Bus,
  output logic [20:0] Addr,
  output logic        EN,
  output logic        WE,
  output logic        Frame_Start,
  output logic        Read_Bank,
  output logic        RGB_PCLK,
  output logic        RGB_HSA,
  output logic        RGB_VSA,
  output logic        RGB_DE,
  output logic [7:0]  RGB_R,
  output logic [7:0]  RGB_G,
  output logic [7:0]  RGB_B
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // One extra count of headroom so the sync-window end bound always fits.
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);

  logic          pix_phase;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [19:0]   pix_idx;
  logic [20:0]   addr_q;

  logic run, active, hsync, vsync, origin, h_wrap, v_wrap, fetch, bank_cur;
  logic unused_bits;

  assign unused_bits = ^Data_Bus[26:24];

  // Reset is folded in so the decoded outputs stay quiet while the block is held in reset.
  assign run    = Display_EN & Reset;
  assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hsync  = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
  assign vsync  = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
  assign origin = (h_cnt == '0) && (v_cnt == '0) && !pix_phase;
  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);
  assign fetch  = run && active && !pix_phase;

  // Read_Bank only loads at the end of the origin cycle, so the first fetch of a
  // frame must already use the bank that is about to be latched.
  assign bank_cur = origin ? ~Bank_Sel : Read_Bank;

  assign EN          = fetch;
  assign Addr        = fetch ? {bank_cur, pix_idx} : addr_q;
  assign Frame_Start = run && origin;
  assign WE          = 1'b0;

  always_ff @(posedge Sys_Clock or negedge Reset) begin
    if (!Reset) begin
      pix_phase <= 1'b0;
      RGB_PCLK  <= 1'b0;
      h_cnt     <= '0;
      v_cnt     <= '0;
      pix_idx   <= '0;
      addr_q    <= '0;
      Read_Bank <= 1'b0;
      RGB_DE    <= 1'b0;
      RGB_HSA   <= 1'b1;
      RGB_VSA   <= 1'b1;
      RGB_R     <= '0;
      RGB_G     <= '0;
      RGB_B     <= '0;
    end else if (!Display_EN) begin
      pix_phase <= 1'b0;
      RGB_PCLK  <= 1'b0;
      h_cnt     <= '0;
      v_cnt     <= '0;
      pix_idx   <= '0;
      addr_q    <= '0;
      Read_Bank <= 1'b0;
      RGB_DE    <= 1'b0;
      RGB_HSA   <= 1'b1;
      RGB_VSA   <= 1'b1;
      RGB_R     <= '0;
      RGB_G     <= '0;
      RGB_B     <= '0;
    end else begin
      // RGB_PCLK is a duplicate of the phase flop so the panel clock comes straight off a register.
      pix_phase <= ~pix_phase;
      RGB_PCLK  <= ~pix_phase;
      if (!pix_phase) begin
        if (active) addr_q <= {bank_cur, pix_idx};
        if (origin) Read_Bank <= ~Bank_Sel;
      end else begin
        // End of slot: SRAM data is valid now, and every panel output moves together
        // on the falling edge of RGB_PCLK.
        RGB_DE  <= active;
        RGB_HSA <= ~hsync;
        RGB_VSA <= ~vsync;
        RGB_R   <= active ? Data_Bus[23:16] : 8'd0;
        RGB_G   <= active ? Data_Bus[15:8]  : 8'd0;
        RGB_B   <= active ? Data_Bus[7:0]   : 8'd0;
        if (h_wrap) begin
          h_cnt <= '0;
          v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
        if (h_wrap && v_wrap) pix_idx <= '0;
        else if (active)      pix_idx <= pix_idx + 20'd1;
      end
    end
  end

endmodule
